inst_fetch_unit: RTL and testbench

//   Instruction fetch stage of the RV32 pipeline. Holds the program counter (PC) and drives
//   the instruction memory address. It registers the returned instruction word, with its PC,

---
 rtl/inst_fetch_unit_if.sv | 41 ++++
 rtl/inst_fetch_unit.sv | 65 ++++++
 tb/tb_inst_fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Bus between the instruction fetch stage, the async-read instruction memory,
// the execute-stage redirect source and the decode stage.
interface inst_fetch_unit_if #(
    parameter int WORD_SIZE = 32
);
    logic                 jmp_ctrl_signal;
    logic [WORD_SIZE-1:0] jump_address;
    logic                 stall;
    logic [WORD_SIZE-1:0] memory_inst_data;
    logic [WORD_SIZE-1:0] memory_inst_address;
    logic [WORD_SIZE-1:0] decode_instruction;
    logic [WORD_SIZE-1:0] decode_pc;
    logic                 decode_valid;
    logic                 inst_misaligned;

    // master: the fetch unit itself
    modport master (
        input  jmp_ctrl_signal,
        input  jump_address,
        input  stall,
        input  memory_inst_data,
        output memory_inst_address,
        output decode_instruction,
        output decode_pc,
        output decode_valid,
        output inst_misaligned
    );

    // slave: memory / execute / decode environment around the fetch unit
    modport slave (
        output jmp_ctrl_signal,
        output jump_address,
        output stall,
        output memory_inst_data,
        input  memory_inst_address,
        input  decode_instruction,
        input  decode_pc,
        input  decode_valid,
        input  inst_misaligned
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, addresses the async-read instruction
// memory and registers the fetched word plus its PC into the fetch/decode register.
module inst_fetch_unit #(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR    = 'h13
) (
    input  logic              clock,
    input  logic              reset,
    inst_fetch_unit_if.master bus
);
    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);

    logic [WORD_SIZE-1:0] pc_reg,          pc_next;
    logic [WORD_SIZE-1:0] instruction_reg, instruction_next;
    logic [WORD_SIZE-1:0] decode_pc_reg,   decode_pc_next;
    logic                 valid_reg,       valid_next;
    logic                 misaligned_reg,  misaligned_next;

    // Priority jump > stall > normal; reset overrides all of it in the register block,
    // so X on the control inputs during reset never reaches state.
    always_comb begin
        pc_next          = pc_reg;
        instruction_next = instruction_reg;
        decode_pc_next   = decode_pc_reg;
        valid_next       = valid_reg;
        misaligned_next  = misaligned_reg;
        if (bus.jmp_ctrl_signal) begin
            // Wrong-path word on memory_inst_data is dropped; the slot becomes a bubble.
            pc_next          = {bus.jump_address[WORD_SIZE-1:2], 2'b00};
            instruction_next = NOP_INSTR;
            decode_pc_next   = pc_reg;
            valid_next       = 1'b0;
            misaligned_next  = |bus.jump_address[1:0];
        end else if (!bus.stall) begin
            pc_next          = pc_reg + PC_STEP;
            instruction_next = bus.memory_inst_data;
            decode_pc_next   = pc_reg;
            valid_next       = 1'b1;
            misaligned_next  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg          <= RESET_VECTOR;
            instruction_reg <= NOP_INSTR;
            decode_pc_reg   <= RESET_VECTOR;
            valid_reg       <= 1'b0;
            misaligned_reg  <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            instruction_reg <= instruction_next;
            decode_pc_reg   <= decode_pc_next;
            valid_reg       <= valid_next;
            misaligned_reg  <= misaligned_next;
        end
    end

    assign bus.memory_inst_address = pc_reg;
    assign bus.decode_instruction  = instruction_reg;
    assign bus.decode_pc           = decode_pc_reg;
    assign bus.decode_valid        = valid_reg;
    assign bus.inst_misaligned     = misaligned_reg;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed + random bench for inst_fetch_unit against a behavioural pipeline model.
module tb_inst_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    inst_fetch_unit_if #(.WORD_SIZE(32)) bus ();

    inst_fetch_unit #(
        .WORD_SIZE   (32),
        .RESET_VECTOR(32'h0000_0000),
        .NOP_INSTR   (NOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    // Instruction memory: pseudo-random word per address, optionally overridden by a fixed word.
    logic [31:0] seed;
    logic        use_fixed;
    logic [31:0] fixed_word;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ seed;
    endfunction

    assign bus.memory_inst_data = use_fixed ? fixed_word : mem_word(bus.memory_inst_address);

    // Reference model state
    logic [31:0] m_pc, m_instr, m_dpc;
    logic        m_valid, m_mis;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  bus.memory_inst_address, m_pc);
        check({tag, ".instr"}, bus.decode_instruction, m_instr);
        check({tag, ".dpc"},   bus.decode_pc, m_dpc);
        check({tag, ".valid"}, {31'd0, bus.decode_valid}, {31'd0, m_valid});
        check({tag, ".mis"},   {31'd0, bus.inst_misaligned}, {31'd0, m_mis});
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, then compare.
    task automatic step(input string tag, input logic rst, input logic jmp,
                        input logic [31:0] target, input logic stl);
        logic [31:0] word;
        reset               = rst;
        bus.jmp_ctrl_signal = jmp;
        bus.jump_address    = target;
        bus.stall           = stl;
        word = use_fixed ? fixed_word : mem_word(m_pc);
        @(posedge clock);
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_dpc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
        end else if (jmp) begin
            m_dpc   = m_pc;
            m_pc    = target & 32'hFFFF_FFFC;
            m_instr = NOP;
            m_valid = 1'b0;
            m_mis   = (target % 4) != 0;
        end else if (!stl) begin
            m_instr = word;
            m_dpc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_mis   = 1'b0;
        end
        #1;
        check_all(tag);
        $display("step %s rst=%0b jmp=%0b tgt=%h stall=%0b -> pc=%h instr=%h dpc=%h v=%0b mis=%0b",
                 tag, rst, jmp, target, stl, bus.memory_inst_address, bus.decode_instruction,
                 bus.decode_pc, bus.decode_valid, bus.inst_misaligned);
    endtask

    initial begin
        logic [31:0] hold_instr;
        seed       = $urandom;
        use_fixed  = 1'b1;
        fixed_word = 32'h3657_3475;
        m_pc = '0; m_instr = NOP; m_dpc = '0; m_valid = 1'b0; m_mis = 1'b0;
        @(negedge clock);

        // Reset with undriven-looking controls asserted
        step("reset", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        step("first", 1'b0, 1'b0, 32'h0, 1'b0);
        check("first.lit_instr", bus.decode_instruction, 32'h3657_3475);
        check("first.lit_addr",  bus.memory_inst_address, 32'h4);

        // Sequential run from 0 with distinct per-address words
        use_fixed = 1'b0;
        step("rst2", 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, 32'h0, 1'b0);
        check("seq.lit_addr", bus.memory_inst_address, 32'd16);

        // Jump to 0x100 issued at pc=8
        step("rst3", 1'b1, 1'b0, 32'h0, 1'b0);
        step("to8a", 1'b0, 1'b0, 32'h0, 1'b0);
        step("to8b", 1'b0, 1'b0, 32'h0, 1'b0);
        step("jmp100", 1'b0, 1'b1, 32'h100, 1'b0);
        check("jmp100.lit_instr", bus.decode_instruction, 32'h13);
        step("after100", 1'b0, 1'b0, 32'h0, 1'b0);
        check("after100.lit_dpc", bus.decode_pc, 32'h100);

        // Misaligned target: flag lasts exactly one cycle
        step("jmp102", 1'b0, 1'b1, 32'h102, 1'b0);
        check("jmp102.lit_mis", {31'd0, bus.inst_misaligned}, 32'd1);
        step("clrmis", 1'b0, 1'b0, 32'h0, 1'b0);

        // Stall for three cycles, then a jump while stall stays high
        hold_instr = bus.decode_instruction;
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 32'h0, 1'b1);
        check("stall.hold", bus.decode_instruction, hold_instr);
        step("stalljmp", 1'b0, 1'b1, 32'h200, 1'b1);

        // Wrap-around at the top of the address space
        step("jmptop", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step("wrap", 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap.lit_addr", bus.memory_inst_address, 32'h0);

        // Reset mid-run while a jump is requested
        step("fill", 1'b0, 1'b0, 32'h0, 1'b0);
        step("rstjmp", 1'b1, 1'b1, 32'h400, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic r, j, s;
            r = ($urandom_range(0, 49) == 0);
            j = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 4) == 0);
            step("rand", r, j, $urandom, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
